// File: rtl/hier_fanout_sequencer.sv
// rtl/hier_fanout_sequencer.sv - hierarchy node launching masked children sequentially or in parallel; timeout built only with HIER_FANOUT_TIMEOUT_EN
module hier_fanout_sequencer #(
    parameter int NUM_CHILD = 5,
    parameter int IDX_W     = (NUM_CHILD > 1) ? $clog2(NUM_CHILD) : 1,
    parameter int TMO_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic                 mode_i,
    input  logic [NUM_CHILD-1:0] child_mask_i,
    input  logic [TMO_W-1:0]     tmo_limit_i,
    output logic [NUM_CHILD-1:0] child_start_o,
    input  logic [NUM_CHILD-1:0] child_done_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic [IDX_W-1:0]     err_idx_o
);

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_FINISH} state_t;

    state_t               state;
    logic                 mode_q;
    logic [NUM_CHILD-1:0] mask_q;
    logic [NUM_CHILD-1:0] remain_q;   // enabled children not yet launched (sequential)
    logic [NUM_CHILD-1:0] cur_q;      // one-hot current child (sequential)
    logic [NUM_CHILD-1:0] seen_q;     // sticky completions (parallel)

    logic [NUM_CHILD-1:0] seen_nxt;
    logic [NUM_CHILD-1:0] next_pick;
    logic [NUM_CHILD-1:0] start_pick;
    logic                 complete;

`ifdef HIER_FANOUT_TIMEOUT_EN
    logic [TMO_W-1:0]     limit_q;
    logic [TMO_W-1:0]     tmo_q;
    logic [TMO_W-1:0]     tmo_nxt;
    logic                 tmo_hit;
    logic [NUM_CHILD-1:0] pend;

    function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_CHILD-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = NUM_CHILD - 1; i >= 0; i--) begin
            if (v[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction
`else
    logic unused_tmo_limit;
    assign unused_tmo_limit = ^tmo_limit_i;
`endif

    // Completion detection and lowest-bit child selection for the current run
    always_comb begin
        seen_nxt   = seen_q | (child_done_i & mask_q);
        next_pick  = remain_q & (~remain_q + NUM_CHILD'(1));
        start_pick = child_mask_i & (~child_mask_i + NUM_CHILD'(1));
        complete   = mode_q ? (seen_nxt == mask_q) : (|(child_done_i & cur_q));
`ifdef HIER_FANOUT_TIMEOUT_EN
        tmo_nxt = (&tmo_q) ? tmo_q : tmo_q + TMO_W'(1);
        tmo_hit = (state == S_WAIT) && (limit_q != '0) && (tmo_nxt >= limit_q);
        pend    = mode_q ? (mask_q & ~seen_nxt) : cur_q;
`endif
    end

    // Control FSM with registered start/done/busy/error outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            mode_q        <= 1'b0;
            mask_q        <= '0;
            remain_q      <= '0;
            cur_q         <= '0;
            seen_q        <= '0;
            child_start_o <= '0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            err_o         <= 1'b0;
            err_idx_o     <= '0;
`ifdef HIER_FANOUT_TIMEOUT_EN
            limit_q       <= '0;
            tmo_q         <= '0;
`endif
        end else begin
            child_start_o <= '0;
            done_o        <= 1'b0;
            case (state)
                // FINISH also accepts a start so back-to-back runs lose no cycle
                S_IDLE, S_FINISH: begin
                    state <= S_IDLE;
                    if (start_i) begin
                        mode_q    <= mode_i;
                        mask_q    <= child_mask_i;
                        seen_q    <= '0;
                        err_o     <= 1'b0;
                        err_idx_o <= '0;
`ifdef HIER_FANOUT_TIMEOUT_EN
                        limit_q   <= tmo_limit_i;
                        tmo_q     <= '0;
`endif
                        if (child_mask_i == '0) begin
                            state  <= S_FINISH;
                            done_o <= 1'b1;
                            busy_o <= 1'b0;
                        end else begin
                            state  <= S_LAUNCH;
                            busy_o <= 1'b1;
                            if (mode_i) begin
                                child_start_o <= child_mask_i;
                                cur_q         <= '0;
                                remain_q      <= '0;
                            end else begin
                                child_start_o <= start_pick;
                                cur_q         <= start_pick;
                                remain_q      <= child_mask_i & ~start_pick;
                            end
                        end
                    end
                end
                // A done in the LAUNCH cycle counts, so both states share the wait logic
                S_LAUNCH, S_WAIT: begin
                    if (complete) begin
                        seen_q <= seen_nxt;
                        if (!mode_q && (remain_q != '0)) begin
                            state         <= S_LAUNCH;
                            child_start_o <= next_pick;
                            cur_q         <= next_pick;
                            remain_q      <= remain_q & ~next_pick;
`ifdef HIER_FANOUT_TIMEOUT_EN
                            tmo_q         <= '0;
`endif
                        end else begin
                            state  <= S_FINISH;
                            done_o <= 1'b1;
                            busy_o <= 1'b0;
                        end
                    end
`ifdef HIER_FANOUT_TIMEOUT_EN
                    else if (tmo_hit) begin
                        state     <= S_FINISH;
                        done_o    <= 1'b1;
                        busy_o    <= 1'b0;
                        err_o     <= 1'b1;
                        err_idx_o <= lowest_idx(pend);
                    end
`endif
                    else begin
                        state  <= S_WAIT;
                        seen_q <= seen_nxt;
`ifdef HIER_FANOUT_TIMEOUT_EN
                        if (state == S_WAIT) tmo_q <= tmo_nxt;
`endif
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hier_fanout_sequencer.sv
// tb/tb_hier_fanout_sequencer.sv - directed-vector bench for hier_fanout_sequencer
module tb_hier_fanout_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_i;
    logic       mode_i;
    logic [4:0] child_mask_i;
    logic [7:0] tmo_limit_i;
    logic [4:0] child_start_o;
    logic [4:0] child_done_i;
    logic       busy_o;
    logic       done_o;
    logic       err_o;
    logic [2:0] err_idx_o;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [4:0] exp_start [0:31];
    logic [4:0] drv_done  [0:31];

    hier_fanout_sequencer #(.NUM_CHILD(5), .TMO_W(8)) dut (
        .clk(clk),
        .rst(rst),
        .start_i(start_i),
        .mode_i(mode_i),
        .child_mask_i(child_mask_i),
        .tmo_limit_i(tmo_limit_i),
        .child_start_o(child_start_o),
        .child_done_i(child_done_i),
        .busy_o(busy_o),
        .done_o(done_o),
        .err_o(err_o),
        .err_idx_o(err_idx_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_tables();
        for (int i = 0; i < 32; i++) begin
            exp_start[i] = '0;
            drv_done[i]  = '0;
        end
    endtask

    // Start is driven in cycle 0; row r is checked/driven in cycle r after acceptance
    task automatic run_table(input string name, input logic m, input logic [4:0] mask,
                             input logic [7:0] lim, input int ncyc, input int done_at,
                             input logic hold);
        mode_i       = m;
        child_mask_i = mask;
        tmo_limit_i  = lim;
        start_i      = 1'b1;
        child_done_i = drv_done[0];
        tick();
        start_i = hold;
        for (int r = 1; r <= ncyc; r++) begin
            child_done_i = drv_done[r];
            check($sformatf("%s start@%0d", name, r), 32'(child_start_o), 32'(exp_start[r]));
            check($sformatf("%s done@%0d", name, r), 32'(done_o), 32'(r == done_at));
            check($sformatf("%s busy@%0d", name, r), 32'(busy_o), 32'(r < done_at));
            tick();
        end
        child_done_i = '0;
    endtask

    initial begin
        rst          = 1'b1;
        start_i      = 1'b0;
        mode_i       = 1'b0;
        child_mask_i = '0;
        tmo_limit_i  = '0;
        child_done_i = '0;
        tick();
        tick();
        check("rst child_start", 32'(child_start_o), 32'h0);
        check("rst busy", 32'(busy_o), 32'h0);
        check("rst done", 32'(done_o), 32'h0);
        check("rst err", 32'(err_o), 32'h0);
        check("rst err_idx", 32'(err_idx_o), 32'h0);
        rst = 1'b0;
        tick();

        // Sequential, mask 10101, each done 3 cycles after its start
        clear_tables();
        exp_start[1] = 5'b00001; exp_start[5] = 5'b00100; exp_start[9] = 5'b10000;
        drv_done[4]  = 5'b00001; drv_done[8]  = 5'b00100; drv_done[12] = 5'b10000;
        run_table("seq10101", 1'b0, 5'b10101, 8'd0, 14, 13, 1'b0);
        check("seq10101 err", 32'(err_o), 32'h0);

        // Parallel, all enabled, dones at +2,+7,+4,+4,+9 plus a repeated done on child 0
        clear_tables();
        exp_start[1] = 5'b11111;
        drv_done[2]  = 5'b00001; drv_done[4] = 5'b01100; drv_done[5] = 5'b00001;
        drv_done[7]  = 5'b00010; drv_done[9] = 5'b10000;
        run_table("par11111", 1'b1, 5'b11111, 8'd0, 11, 10, 1'b0);

        // Parallel, mask 00110: same-cycle done counts, masked-off done ignored
        clear_tables();
        exp_start[1] = 5'b00110;
        drv_done[1]  = 5'b00011; drv_done[3] = 5'b00001; drv_done[5] = 5'b00100;
        run_table("par00110", 1'b1, 5'b00110, 8'd0, 7, 6, 1'b0);

        // All-zero mask: immediate done, no launches, never busy
        clear_tables();
        run_table("mask0", 1'b0, 5'b00000, 8'd0, 2, 1, 1'b0);

        // Start held high during a run: relaunch only from the done_o cycle
        clear_tables();
        exp_start[1] = 5'b00001;
        drv_done[3]  = 5'b00001;
        run_table("hold", 1'b0, 5'b00001, 8'd0, 4, 4, 1'b1);
        start_i = 1'b0;
        check("hold relaunch start", 32'(child_start_o), 32'h01);
        check("hold relaunch busy", 32'(busy_o), 32'h1);
        child_done_i = 5'b00001;
        tick();
        child_done_i = '0;
        check("hold relaunch done", 32'(done_o), 32'h1);
        check("hold relaunch idle", 32'(busy_o), 32'h0);
        tick();

        // Stray done on child 3 while child 1 is active
        clear_tables();
        exp_start[1] = 5'b00010; exp_start[4] = 5'b01000;
        drv_done[2]  = 5'b01000; drv_done[3]  = 5'b00010; drv_done[5] = 5'b01000;
        run_table("stray", 1'b0, 5'b01010, 8'd0, 7, 6, 1'b0);

`ifdef HIER_FANOUT_TIMEOUT_EN
        // Timeout: limit 4, child 2 never completes
        clear_tables();
        exp_start[1] = 5'b00100;
        run_table("tmo", 1'b0, 5'b00100, 8'd4, 7, 6, 1'b0);
        check("tmo err", 32'(err_o), 32'h1);
        check("tmo err_idx", 32'(err_idx_o), 32'h2);
        // Hung run with timeout disabled; the accepted start clears the error
        mode_i = 1'b0; child_mask_i = 5'b00100; tmo_limit_i = 8'd0; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("hang start", 32'(child_start_o), 32'h04);
        check("hang err cleared", 32'(err_o), 32'h0);
        for (int i = 0; i < 12; i++) begin
            tick();
            check($sformatf("hang busy@%0d", i), 32'(busy_o), 32'h1);
        end
`else
        // No timeout hardware: a nonzero limit must not end the wait
        mode_i = 1'b0; child_mask_i = 5'b00100; tmo_limit_i = 8'd4; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("hang start", 32'(child_start_o), 32'h04);
        for (int i = 0; i < 12; i++) begin
            tick();
            check($sformatf("hang busy@%0d", i), 32'(busy_o), 32'h1);
            check($sformatf("hang done@%0d", i), 32'(done_o), 32'h0);
            check($sformatf("hang err@%0d", i), 32'(err_o), 32'h0);
        end
`endif

        // Asynchronous reset mid-wait clears outputs without a clock edge
        #2;
        rst = 1'b1;
        #1;
        check("async rst busy", 32'(busy_o), 32'h0);
        check("async rst start", 32'(child_start_o), 32'h0);
        check("async rst done", 32'(done_o), 32'h0);
        check("async rst err", 32'(err_o), 32'h0);
        check("async rst err_idx", 32'(err_idx_o), 32'h0);
        tick();
        rst = 1'b0;
        tick();

        // Fresh sequential run after reset begins at child 0
        clear_tables();
        exp_start[1] = 5'b00001; exp_start[3] = 5'b00010;
        drv_done[2]  = 5'b00001; drv_done[3]  = 5'b00010;
        run_table("post_rst", 1'b0, 5'b00011, 8'd0, 5, 4, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
